shift_engine: RTL

//  Parametrised universal shift register with a burst-shift controller. Supports parallel

---
 rtl/shift_engine.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/shift_engine.sv
// ----------------------------------------------------------------------------
// shift_engine
//   Universal W-bit shift register with a counted burst-shift controller.
//   Supports parallel load, synchronous clear, single-step shifts and a burst
//   of N shifts requested with a start/busy/done handshake.
//   Ops: 000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 ASR, others hold.
//
// Ports
//   ck        : clock, all state updates on the rising edge
//   rst       : synchronous reset, active high
//   clr       : synchronous clear of q (aborts a burst, no done pulse)
//   ld        : parallel load q <= d (IDLE only)
//   d         : parallel load data
//   op        : shift operation code
//   step      : single shift with live op (IDLE only)
//   start     : begin a burst of count shifts (IDLE only)
//   count     : burst length 0..W, larger values clamp to W
//   serialIn  : fill bit for SHL / SHR
//   q         : register contents
//   serialOut : bit shifted out by the most recent shift
//   busy      : high while a burst is in progress
//   done      : one-cycle pulse after the last burst shift
// ----------------------------------------------------------------------------
module shift_engine #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          clr,
    input  logic          ld,
    input  logic [W-1:0]  d,
    input  logic [2:0]    op,
    input  logic          step,
    input  logic          start,
    input  logic [CW-1:0] count,
    input  logic          serialIn,
    output logic [W-1:0]  q,
    output logic          serialOut,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [2:0]     op_lat;
    logic [CW-1:0]  rem;
    logic [CW-1:0]  cnt_clamped;
    logic [2:0]     op_eff;
    logic [W:0]     shift_res;

    // Returns {serial_out, q_next}; reserved codes hold both.
    function automatic logic [W:0] shift_fn(
        input logic [2:0]   sop,
        input logic [W-1:0] sq,
        input logic         sin,
        input logic         so_prev
    );
        case (sop)
            3'b000:  shift_fn = {sq[W-1], sq[W-2:0], sin};
            3'b001:  shift_fn = {sq[0],   sin, sq[W-1:1]};
            3'b010:  shift_fn = {sq[W-1], sq[W-2:0], sq[W-1]};
            3'b011:  shift_fn = {sq[0],   sq[0], sq[W-1:1]};
            3'b100:  shift_fn = {sq[0],   sq[W-1], sq[W-1:1]};
            default: shift_fn = {so_prev, sq};
        endcase
    endfunction

    assign cnt_clamped = (count > CW'(W)) ? CW'(W) : count;

    // Mid-burst the latched op is used so live op changes are ignored.
    assign op_eff    = (state == SHIFT) ? op_lat : op;
    assign shift_res = shift_fn(op_eff, q, serialIn, serialOut);

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!ld && start) begin
                        state_nx = (cnt_clamped == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (rem == CW'(1)) begin
                        state_nx = DONE;
                    end
                end
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state     <= IDLE;
            q         <= '0;
            serialOut <= 1'b0;
            op_lat    <= '0;
            rem       <= '0;
        end else begin
            state <= state_nx;
            if (clr) begin
                q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ld) begin
                            q <= d;
                        end else if (start) begin
                            if (cnt_clamped != '0) begin
                                op_lat <= op;
                                rem    <= cnt_clamped;
                            end
                        end else if (step) begin
                            {serialOut, q} <= shift_res;
                        end
                    end
                    SHIFT: begin
                        {serialOut, q} <= shift_res;
                        rem            <= rem - CW'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Decoded straight from the state register: no input-to-output path.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
